cp0: RTL



---
 rtl/cp0_pkg.sv | 46 ++++
 rtl/cp0_req.sv | 26 ++
 rtl/cp0.sv | 94 +++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, exception codes, field positions
// and the exception handler entry point used by the fetch stage.
package cp0_defs;

  // CP0 register indices as seen by mfc0/mtc0
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // Exception codes carried down the pipeline
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Field bit positions
  localparam int IM_HI  = 15;
  localparam int IM_LO  = 10;
  localparam int EXL_B  = 1;
  localparam int IE_B   = 0;
  localparam int BD_B   = 31;
  localparam int IP_HI  = 15;
  localparam int IP_LO  = 10;
  localparam int EXC_HI = 6;
  localparam int EXC_LO = 2;

  // Handler address, shared with the fetch stage flush logic
  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  // Assemble the architectural SR view; unimplemented bits read 0
  function automatic logic [31:0] pack_sr(input logic [5:0] im,
                                          input logic exl,
                                          input logic ie);
    return {16'd0, im, 8'd0, exl, ie};
  endfunction

  // Assemble the architectural Cause view; unimplemented bits read 0
  function automatic logic [31:0] pack_cause(input logic       bd,
                                             input logic [5:0] ip,
                                             input logic [4:0] exc_code);
    return {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
  endfunction

endpackage

// File: rtl/cp0_req.sv
// Combinational request logic: decides whether an interrupt or exception is
// taken this cycle and which ExcCode gets recorded.
module cp0_req
  import cp0_defs::*;
(
  input  logic [5:0] hw_int,
  input  logic [5:0] im,
  input  logic       ie,
  input  logic       exl,
  input  logic [4:0] exc_code_in,
  output logic       int_req,
  output logic [4:0] exc_code_sel
);

  logic irq;
  logic exc;

  // An enabled interrupt outranks a simultaneous synchronous exception
  always_comb begin
    irq          = (|(hw_int & im)) & ie & ~exl;
    exc          = (exc_code_in != EXC_INT) & ~exl;
    int_req      = irq | exc;
    exc_code_sel = irq ? EXC_INT : exc_code_in;
  end

endmodule

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC/PRId state, exception commit in MEM, mfc0/mtc0.
module cp0
  import cp0_defs::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h5043_5037
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] Din,
  input  logic        WE,
  input  logic [31:0] pc_MEM,
  input  logic        BD_in,
  input  logic [4:0]  ExcCode_in,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPC,
  output logic [31:0] Dout
);

  logic [5:0]  im_q;
  logic        exl_q;
  logic        ie_q;
  logic        bd_q;
  logic [5:0]  ip_q;
  logic [4:0]  exc_code_q;
  logic [31:0] epc_q;

  logic        int_req;
  logic [4:0]  exc_code_sel;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  cp0_req u_req (
    .hw_int       (HWInt),
    .im           (im_q),
    .ie           (ie_q),
    .exl          (exl_q),
    .exc_code_in  (ExcCode_in),
    .int_req      (int_req),
    .exc_code_sel (exc_code_sel)
  );

  // State update; priority is reset, then exception entry, then eret, then mtc0
  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      ip_q <= HWInt;
      if (int_req) begin
        exl_q      <= 1'b1;
        exc_code_q <= exc_code_sel;
        bd_q       <= BD_in;
        epc_q      <= BD_in ? (pc_MEM - 32'd4) : pc_MEM;
      end else if (EXLClr) begin
        exl_q <= 1'b0;
      end else if (WE) begin
        case (A2)
          REG_SR: begin
            im_q  <= Din[IM_HI:IM_LO];
            exl_q <= Din[EXL_B];
            ie_q  <= Din[IE_B];
          end
          REG_EPC: epc_q <= Din;
          default: ;
        endcase
      end
    end
  end

  // Read mux and EPC forwarding so an eret right after mtc0 EPC sees the new value
  always_comb begin
    sr_word    = pack_sr(im_q, exl_q, ie_q);
    cause_word = pack_cause(bd_q, ip_q, exc_code_q);
    IntReq     = int_req;
    EPC        = (WE && (A2 == REG_EPC) && !int_req) ? Din : epc_q;
    case (A1)
      REG_SR:    Dout = sr_word;
      REG_CAUSE: Dout = cause_word;
      REG_EPC:   Dout = epc_q;
      REG_PRID:  Dout = PRID_VALUE;
      default:   Dout = 32'd0;
    endcase
  end

endmodule
